// File: rtl/cpu_datamem_ws_if.sv
// cpu_datamem_ws_if
//   Bus between the CPU memory stage (master) and the wait-stated data
//   memory (slave).
//   Request side (master -> slave):
//     req        request strobe
//     MemRd      read qualifier
//     MemWr      write qualifier
//     Size       00 byte, 01 halfword, 10 word, 11 reserved
//     Unsigned   zero-extend sub-word loads when 1
//     Addr       byte address
//     WriteData  store data (sub-word stores use the low bits)
//   Response side (slave -> master):
//     ReadData   registered, already-extended load result
//     ack        one-cycle completion pulse
//     busy       high while a request is in flight
//     AddrErr    error status of the completing request
interface cpu_datamem_ws_if;
    logic        req;
    logic        MemRd;
    logic        MemWr;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        ack;
    logic        busy;
    logic        AddrErr;

    modport master (
        output req, MemRd, MemWr, Size, Unsigned, Addr, WriteData,
        input  ReadData, ack, busy, AddrErr
    );

    modport slave (
        input  req, MemRd, MemWr, Size, Unsigned, Addr, WriteData,
        output ReadData, ack, busy, AddrErr
    );
endinterface

// File: rtl/cpu_datamem_ws.sv
// cpu_datamem_ws
//   Word-organised little-endian data memory with byte/half/word access,
//   sign/zero extension, configurable wait states, a req/ack/busy handshake,
//   registered read data and misalignment / out-of-range error reporting.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset (RAM contents are not cleared)
//     bus    cpu_datamem_ws_if.slave request/response bundle
//   Parameters:
//     RAM_WORDS    number of 32-bit words
//     WAIT_STATES  extra cycles before the access (0..15)
module cpu_datamem_ws #(
    parameter int RAM_WORDS   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             reset,
    cpu_datamem_ws_if.slave  bus
);

    localparam int          IDXW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] RAM_WORDS_U = 32'(RAM_WORDS);
    localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic [31:0] mem [RAM_WORDS];

    logic [IDXW-1:0] idx;
    logic [31:0]     memWord;
    logic [31:0]     shifted;
    logic [31:0]     loadVal;
    logic [31:0]     wdataLane;
    logic [3:0]      byteEn;
    logic            accErr;
    logic            memWe;

    // Any of these makes the request an error: it completes without touching
    // RAM. The range check uses all of Addr[31:2], so there is no aliasing.
    function automatic logic addrError(input logic [31:0] a, input logic [1:0] sz,
                                       input logic rd, input logic wr);
        logic e;
        e = 1'b0;
        if (sz == 2'b11)                        e = 1'b1;
        if (sz == 2'b01 && a[0])                e = 1'b1;
        if (sz == 2'b10 && a[1:0] != 2'b00)     e = 1'b1;
        if ({2'b00, a[31:2]} >= RAM_WORDS_U)    e = 1'b1;
        if (rd && wr)                           e = 1'b1;
        return e;
    endfunction

    assign idx    = addr_q[IDXW+1:2];
    assign accErr = addrError(addr_q, size_q, rd_q, wr_q);

    // Lane steering. Legal sub-word accesses are naturally aligned, so a
    // single byte-granular shift right-justifies both bytes and halfwords.
    always_comb begin
        memWord   = mem[idx];
        shifted   = memWord >> {addr_q[1:0], 3'b000};
        loadVal   = shifted;
        byteEn    = 4'b1111;
        wdataLane = wdata_q;
        case (size_q)
            2'b00: begin
                loadVal   = uns_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                byteEn    = 4'b0001 << addr_q[1:0];
                wdataLane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                loadVal   = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
                byteEn    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdataLane = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Next-state logic. Erroring requests go straight to ACCESS so they
    // complete one cycle after acceptance regardless of WAIT_STATES.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;
        memWe   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req && (bus.MemRd || bus.MemWr)) begin
                    addr_d  = bus.Addr;
                    wdata_d = bus.WriteData;
                    size_d  = bus.Size;
                    uns_d   = bus.Unsigned;
                    rd_d    = bus.MemRd;
                    wr_d    = bus.MemWr;
                    busy_d  = 1'b1;
                    if (addrError(bus.Addr, bus.Size, bus.MemRd, bus.MemWr)) begin
                        state_d = S_ACCESS;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ack_d   = 1'b1;
                busy_d  = 1'b0;
                err_d   = accErr;
                state_d = S_IDLE;
                memWe   = wr_q && !accErr;
                if (rd_q) begin
                    rdata_d = accErr ? 32'h0 : loadVal;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // RAM is deliberately not reset. A reset mid-request forces IDLE, so
    // memWe can never fire for an aborted access.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[idx][8*i +: 8] <= wdataLane[8*i +: 8];
                end
            end
        end
    end

    assign bus.ReadData = rdata_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;
    assign bus.AddrErr  = err_q;

endmodule

// File: doc/cpu_datamem_ws.md
Name: cpu_datamem_ws

Overview:
- Parametrised data memory for the multi-cycle/pipelined CPU.
- Adds to the single-cycle data memory:
  - byte, halfword and word access with sign/zero extension
  - configurable wait states
  - req/ack/busy handshake
  - registered read data
  - misalignment and out-of-range error reporting
- Sits between the CPU memory stage and word-organised little-endian RAM.
- The CPU stalls on busy and consumes ReadData/AddrErr on ack.

Parameters:
- RAM_WORDS, 256: number of 32-bit words. Valid word index is 0..RAM_WORDS-1.
- WAIT_STATES, 0: extra cycles inserted before the access. Legal range 0..15. The counter is 4 bits wide.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request strobe; sampled only in IDLE.
- MemRd  input  1  read request qualifier.
- MemWr  input  1  write request qualifier.
- Size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- Unsigned  input  1  zero-extend a sub-word read when 1; sign-extend when 0.
- Addr  input  32  byte address.
- WriteData  input  32  store data; sub-word stores use the low bits.
- ReadData  output  32  registered load result, already extended.
- ack  output  1  one-cycle completion pulse, registered.
- busy  output  1  high while a request is in flight, registered.
- AddrErr  output  1  error status of the completing request; valid while ack=1.

Behaviour:
- Reset (reset=0, async): state=IDLE, wait counter=0, ReadData=0, ack=0, busy=0, AddrErr=0. RAM contents are not cleared.
- States: IDLE, WAIT, ACCESS.
- IDLE:
  - If req=1 and (MemRd|MemWr)=1 at an edge, capture Addr, WriteData, Size, Unsigned, MemRd and MemWr. Set busy=1.
  - Next state is WAIT with count=WAIT_STATES if WAIT_STATES>0, otherwise ACCESS.
  - req with MemRd=MemWr=0 is ignored.
- WAIT:
  - Decrement the counter each cycle. Go to ACCESS when the counter reaches 1.
  - req and all other inputs are ignored; captured values are used.
- ACCESS (one cycle): at its closing edge, perform the write or read, pulse ack=1, clear busy=0, return to IDLE.
  - A new req may be sampled in the cycle where ack=1, giving back-to-back throughput.
- Latency: req accepted at edge E gives ack=1 in the cycle after edge E+WAIT_STATES+1.
  - Example: WAIT_STATES=0 gives ack in the cycle after E+1.
- Error conditions, checked on the captured values:
  - Size=11
  - Size=01 with Addr[0]=1
  - Size=10 with Addr[1:0]!=00
  - Addr[31:2] >= RAM_WORDS
  - MemRd=MemWr=1
- Error handling:
  - An erroring request skips WAIT entirely: ack=1 and AddrErr=1 in the cycle after E+1.
  - No RAM write occurs. A read error sets ReadData=0.
- AddrErr is cleared on the next ack with no error. It is held otherwise.
- Write lanes (little-endian):
  - byte: lane Addr[1:0] gets WriteData[7:0]
  - half: Addr[1]=0 gets bits [15:0], Addr[1]=1 gets bits [31:16], from WriteData[15:0]
  - word: full overwrite
  - Untouched lanes keep their old value.
- Read extraction:
  - Select the same lane(s) as a write and right-justify.
  - Unsigned=0: sign-extend from bit 7 (byte) or bit 15 (half).
  - Unsigned=1: zero-extend.
  - Word reads ignore Unsigned.
- ReadData is updated only on a read completion, or set to 0 on a read error. A write completion leaves it unchanged.
- Read-after-write: a read that completes after the write's ack returns the new data; no same-cycle hazard exists.
- Reset mid-operation: the access is aborted. No write occurs unless the ACCESS closing edge already happened. Outputs take their reset values.
- Address bits [31:2] beyond log2(RAM_WORDS) must be zero to pass the range check; there is no aliasing.

Test Plan:
1. WAIT_STATES=0: write word 0xDEADBEEF at 0x10, then read word at 0x10.
   -> each ack arrives 1 cycle after the accept edge; ReadData=0xDEADBEEF; busy high for exactly 1 cycle per access.
2. Byte write 0x80 at 0x11 over word 0x00000000, then read byte at 0x11 with Unsigned=0 and again with Unsigned=1, then read word at 0x10.
   -> byte reads give 0xFFFFFF80, then 0x00000080; word read gives 0x00008000.
3. Half write 0xABCD at 0x22 over 0x11112222, then read half at 0x22 with Unsigned=0, then read word at 0x20.
   -> half read gives 0xFFFFABCD; word read gives 0xABCD2222.
4. Errors: word read at 0x13; half write at 0x21; Size=11; word read at 4*RAM_WORDS (0x400).
   -> each gives ack 1 cycle after accept with AddrErr=1 and no RAM change; reads give ReadData=0. A following legal read clears AddrErr.
5. WAIT_STATES=3: read, with a second req asserted during the wait.
   -> ack arrives 4 cycles after the accept edge; the second req is ignored until IDLE; req held high in the ack cycle is accepted back-to-back.
6. Assert reset during WAIT of a write of 0x12345678 over 0xCAFEF00D.
   -> ack=0, busy=0 and ReadData=0 immediately; a later read returns 0xCAFEF00D.
